// File: rtl/i2c_txn_sequencer.sv
// Command FIFO and issue sequencer in front of an I2C master.
// Pops one queued transaction at a time and returns read data or timeouts.
module i2c_txn_sequencer #(
    parameter int DEPTH          = 4,
    parameter int ENABLE_CYCLES  = 5,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [6:0]               cmd_addr,
    input  logic                     cmd_rw,
    input  logic [7:0]               cmd_data,
    output logic [6:0]               m_address,
    output logic [7:0]               m_data_in,
    output logic                     m_rw,
    output logic                     m_enable,
    input  logic                     m_ready,
    input  logic [7:0]               m_data_out,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [7:0]               rsp_data,
    output logic [6:0]               rsp_addr,
    output logic                     rsp_err,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = (ENABLE_CYCLES > 1) ? $clog2(ENABLE_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        RESPOND
    } state_t;

    state_t state, state_d;

    // Entry layout: {rw, addr[6:0], data[7:0]}
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic [EW-1:0] en_cnt;
    logic [TW-1:0] to_cnt;
    logic          saw_low;

    logic push;
    logic pop;
    logic en_last;
    logic to_fire;
    logic timed_out;

    assign cmd_ready  = (count != CW'(DEPTH));
    assign fifo_count = count;
    assign push       = cmd_valid && cmd_ready;
    assign pop        = (state == IDLE) && (count != '0) && m_ready;
    assign en_last    = (en_cnt == EW'(ENABLE_CYCLES - 1));
    assign to_fire    = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign busy       = (state != IDLE) || (count != '0);

    always_comb begin
        state_d   = state;
        timed_out = 1'b0;
        unique case (state)
            IDLE: begin
                if (pop) state_d = ISSUE;
            end
            ISSUE: begin
                // A master that already went busy skips the busy wait
                if (en_last)
                    state_d = (saw_low || !m_ready) ? WAIT_DONE : WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!m_ready) begin
                    state_d = WAIT_DONE;
                end else if (to_fire) begin
                    state_d   = RESPOND;
                    timed_out = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (m_ready) begin
                    state_d = m_rw ? RESPOND : IDLE;
                end else if (to_fire) begin
                    state_d   = RESPOND;
                    timed_out = 1'b1;
                end
            end
            RESPOND: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cmd_rw, cmd_addr, cmd_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            en_cnt    <= '0;
            to_cnt    <= '0;
            saw_low   <= 1'b0;
            m_address <= '0;
            m_data_in <= '0;
            m_rw      <= 1'b0;
            m_enable  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_addr  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_d;

            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (pop)
                {m_rw, m_address, m_data_in} <= mem[rd_ptr];

            if (state == ISSUE) en_cnt <= en_cnt + EW'(1);
            else                en_cnt <= '0;

            if (pop) begin
                m_enable <= 1'b1;
                saw_low  <= 1'b0;
            end else if (state == ISSUE) begin
                if (en_last)  m_enable <= 1'b0;
                if (!m_ready) saw_low  <= 1'b1;
            end

            // Saturating wait counter, restarted on every state change
            if (state_d != state)
                to_cnt <= '0;
            else if (to_cnt != TW'(TIMEOUT_CYCLES))
                to_cnt <= to_cnt + TW'(1);

            if (state != RESPOND && state_d == RESPOND) begin
                rsp_valid <= 1'b1;
                rsp_addr  <= m_address;
                rsp_err   <= timed_out;
                rsp_data  <= timed_out ? 8'h00 : m_data_out;
            end else if (state == RESPOND && rsp_ready) begin
                rsp_valid <= 1'b0;
                rsp_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Directed bench for i2c_txn_sequencer with a small I2C master model.
// Each scenario task drives stimulus and checks its own expectations.
module tb_i2c_txn_sequencer;

    localparam logic [6:0] SLAVE = 7'h2A;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [6:0] cmd_addr = '0;
    logic       cmd_rw = 1'b0;
    logic [7:0] cmd_data = '0;
    logic [6:0] m_address;
    logic [7:0] m_data_in;
    logic       m_rw;
    logic       m_enable;
    logic       m_ready = 1'b1;
    logic [7:0] m_data_out = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_data;
    logic [6:0] rsp_addr;
    logic       rsp_err;
    logic       busy;
    logic [2:0] fifo_count;

    int checks = 0;
    int errors = 0;

    i2c_txn_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_data(cmd_data),
        .m_address(m_address), .m_data_in(m_data_in), .m_rw(m_rw),
        .m_enable(m_enable), .m_ready(m_ready), .m_data_out(m_data_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_addr(rsp_addr), .rsp_err(rsp_err),
        .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Master model state
    logic       hang = 1'b0;
    logic       hold = 1'b0;
    logic       active = 1'b0;
    int         tcnt = 0;
    logic [6:0] taddr = '0;
    logic [7:0] rx_byte = '0;
    logic [7:0] lg [$];
    logic [15:0] rq [$];
    int         vcyc = 0;

    function automatic logic [7:0] tx_byte(input logic [6:0] a);
        case (a)
            7'h33:   return 8'h55;
            7'h2A:   return 8'hF0;
            7'h1D:   return 8'h99;
            default: return 8'hFF;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst || hang) begin
            m_ready = 1'b1;
            active  = 1'b0;
        end else if (hold) begin
            m_ready = 1'b0;
        end else if (!active) begin
            m_ready = 1'b1;
            if (m_enable) begin
                active = 1'b1;
                tcnt   = 0;
                taddr  = m_address;
                lg.push_back({m_rw, m_address});
                if (!m_rw && m_address == SLAVE) rx_byte = m_data_in;
            end
        end else begin
            tcnt++;
            if (tcnt == 2) m_ready = 1'b0;
            if (tcnt == 12) begin
                m_ready    = 1'b1;
                m_data_out = tx_byte(taddr);
                active     = 1'b0;
            end
        end
    end

    // Response monitor samples pre-edge values
    always @(posedge clk) begin
        if (!rst && rsp_valid) vcyc++;
        if (!rst && rsp_valid && rsp_ready)
            rq.push_back({rsp_err, rsp_addr, rsp_data});
    end

    task automatic push_cmd(input logic [6:0] a, input logic rw,
                            input logic [7:0] d);
        int n;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_rw    = rw;
        cmd_data  = d;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL push_accept got %b want 1", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        while ((busy || active) && n < lim) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout busy got %b want 0", busy);
        end
    endtask

    task automatic wait_enable();
        int n;
        n = 0;
        while (!m_enable && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (m_enable !== 1'b1) begin
            errors++;
            $display("FAIL enable_wait got %b want 1", m_enable);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({m_enable, m_rw, rsp_valid, rsp_err} !== 4'b0) begin
            errors++;
            $display("FAIL rst_ctrl got %b want 0000",
                     {m_enable, m_rw, rsp_valid, rsp_err});
        end
        checks++;
        if ({m_address, m_data_in, rsp_data, rsp_addr} !== 30'h0) begin
            errors++;
            $display("FAIL rst_data got %h want 0",
                     {m_address, m_data_in, rsp_data, rsp_addr});
        end
        checks++;
        if ({cmd_ready, busy, fifo_count} !== 5'b10000) begin
            errors++;
            $display("FAIL rst_fifo got %b want 10000",
                     {cmd_ready, busy, fifo_count});
        end
    endtask

    task automatic test_write();
        int en_n;
        int v0;
        logic stable;
        rsp_ready = 1'b1;
        v0 = vcyc;
        push_cmd(7'h2A, 1'b0, 8'hA5);
        wait_enable();
        en_n   = 0;
        stable = 1'b1;
        while (m_enable && en_n < 50) begin
            if (m_address !== 7'h2A || m_data_in !== 8'hA5 || m_rw !== 1'b0)
                stable = 1'b0;
            en_n++;
            @(negedge clk);
        end
        wait_idle(200);
        checks++;
        if (en_n != 5) begin
            errors++;
            $display("FAIL wr_enable_len got %0d want 5", en_n);
        end
        checks++;
        if (stable !== 1'b1) begin
            errors++;
            $display("FAIL wr_stable got %b want 1", stable);
        end
        checks++;
        if (rx_byte !== 8'hA5) begin
            errors++;
            $display("FAIL wr_slave_rx got %h want a5", rx_byte);
        end
        checks++;
        if (vcyc != v0) begin
            errors++;
            $display("FAIL wr_no_rsp got %0d want %0d", vcyc, v0);
        end
    endtask

    task automatic test_read();
        int v0;
        rsp_ready = 1'b1;
        rq.delete();
        v0 = vcyc;
        push_cmd(7'h33, 1'b1, 8'h00);
        wait_idle(200);
        checks++;
        if (rq.size() != 1) begin
            errors++;
            $display("FAIL rd_rsp_count got %0d want 1", rq.size());
        end else begin
            checks++;
            if (rq[0] !== {1'b0, 7'h33, 8'h55}) begin
                errors++;
                $display("FAIL rd_rsp got %h want %h", rq[0],
                         {1'b0, 7'h33, 8'h55});
            end
        end
        checks++;
        if (vcyc - v0 != 1) begin
            errors++;
            $display("FAIL rd_pulse got %0d want 1", vcyc - v0);
        end
    endtask

    task automatic test_fifo_order();
        logic [7:0] exp_lg [4];
        exp_lg[0] = {1'b0, 7'h2A};
        exp_lg[1] = {1'b1, 7'h33};
        exp_lg[2] = {1'b0, 7'h1D};
        exp_lg[3] = {1'b1, 7'h1D};
        rsp_ready = 1'b1;
        lg.delete();
        rq.delete();
        hold = 1'b1;
        repeat (2) @(negedge clk);
        push_cmd(7'h2A, 1'b0, 8'h77);
        push_cmd(7'h33, 1'b1, 8'h00);
        push_cmd(7'h1D, 1'b0, 8'h3C);
        push_cmd(7'h1D, 1'b1, 8'h00);
        checks++;
        if ({cmd_ready, fifo_count} !== 4'b0100) begin
            errors++;
            $display("FAIL fifo_full got %b want 0100",
                     {cmd_ready, fifo_count});
        end
        hold = 1'b0;
        wait_idle(500);
        checks++;
        if (lg.size() != 4) begin
            errors++;
            $display("FAIL fifo_txn_count got %0d want 4", lg.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (lg[i] !== exp_lg[i]) begin
                    errors++;
                    $display("FAIL fifo_order[%0d] got %h want %h",
                             i, lg[i], exp_lg[i]);
                end
            end
        end
        checks++;
        if (rq.size() != 2) begin
            errors++;
            $display("FAIL fifo_rsp_count got %0d want 2", rq.size());
        end else begin
            checks++;
            if (rq[0] !== {1'b0, 7'h33, 8'h55} ||
                rq[1] !== {1'b0, 7'h1D, 8'h99}) begin
                errors++;
                $display("FAIL fifo_rsp_order got %h %h want 3355 1d99",
                         rq[0], rq[1]);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        int ln;
        logic held;
        rq.delete();
        lg.delete();
        rsp_ready = 1'b0;
        push_cmd(7'h2A, 1'b1, 8'h00);
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        push_cmd(7'h1D, 1'b0, 8'h3C);
        ln   = lg.size();
        held = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (rsp_valid !== 1'b1 || rsp_data !== 8'hF0 ||
                rsp_addr !== 7'h2A || m_enable !== 1'b0)
                held = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (held !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold got %b want 1", held);
        end
        checks++;
        if (fifo_count !== 3'd1 || lg.size() != ln) begin
            errors++;
            $display("FAIL bp_queued got cnt %0d txns %0d want 1 %0d",
                     fifo_count, lg.size(), ln);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (m_enable !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_gap got en %b v %b want 0 0",
                     m_enable, rsp_valid);
        end
        wait_enable();
        wait_idle(200);
        checks++;
        if (rq.size() != 1 || lg.size() != ln + 1) begin
            errors++;
            $display("FAIL bp_counts got rsp %0d txns %0d want 1 %0d",
                     rq.size(), lg.size(), ln + 1);
        end else begin
            checks++;
            if (rq[0] !== {1'b0, 7'h2A, 8'hF0} ||
                lg[ln] !== {1'b0, 7'h1D}) begin
                errors++;
                $display("FAIL bp_data got %h %h want 2af0 1d",
                         rq[0], lg[ln]);
            end
        end
    endtask

    task automatic test_timeout();
        int c;
        hang      = 1'b1;
        rsp_ready = 1'b0;
        push_cmd(7'h10, 1'b1, 8'h00);
        wait_enable();
        c = 0;
        while (!rsp_valid && c < 2000) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (c != 1029) begin
            errors++;
            $display("FAIL to_latency got %0d want 1029", c);
        end
        checks++;
        if ({rsp_valid, rsp_err, rsp_addr, rsp_data} !==
            {1'b1, 1'b1, 7'h10, 8'h00}) begin
            errors++;
            $display("FAIL to_rsp got %b %b %h %h want 1 1 10 00",
                     rsp_valid, rsp_err, rsp_addr, rsp_data);
        end
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_err} !== 2'b00) begin
            errors++;
            $display("FAIL to_ack got %b want 00", {rsp_valid, rsp_err});
        end
        hang = 1'b0;
        wait_idle(50);
    endtask

    task automatic test_reset_mid();
        int n;
        int v0;
        rsp_ready = 1'b1;
        push_cmd(7'h33, 1'b1, 8'h00);
        push_cmd(7'h2A, 1'b0, 8'h11);
        push_cmd(7'h1D, 1'b1, 8'h00);
        n = 0;
        while ((m_enable || m_ready) && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ({m_enable, m_ready, fifo_count} !== 5'b00010) begin
            errors++;
            $display("FAIL mid_setup got %b want 00010",
                     {m_enable, m_ready, fifo_count});
        end
        v0  = vcyc;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({fifo_count, m_enable, rsp_valid, cmd_ready, busy} !==
            7'b0000010) begin
            errors++;
            $display("FAIL mid_reset got %b want 0000010",
                     {fifo_count, m_enable, rsp_valid, cmd_ready, busy});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if (vcyc != v0 || busy !== 1'b0 || m_enable !== 1'b0) begin
            errors++;
            $display("FAIL mid_quiet got v %0d busy %b en %b want %0d 0 0",
                     vcyc, busy, m_enable, v0);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_fifo_order();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
